// File: rtl/gate_test_sequencer.sv
// Sweeps every input vector of a gate under test and tallies matches against the ideal truth table.
// Define GATE_SEQ_STOP_ON_FAIL_EN to end a sweep at the first mismatching vector.
module gate_test_sequencer #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      gate_sel,
  input  logic            dut_y,
  output logic [N_IN-1:0] stim,
  output logic            busy,
  output logic            done,
  output logic [N_IN:0]   pass_cnt,
  output logic [N_IN:0]   fail_cnt,
  output logic            err_valid,
  output logic [N_IN-1:0] err_vec
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_CHECK  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;
  localparam int         CNT_W     = N_IN + 1;

  logic [1:0] state;
  logic [3:0] wait_cnt;
  logic [2:0] gate_q;
  logic       expected;
  logic       mismatch;
  logic       last_vec;

  // Ideal response of the latched gate; NOT and BUF only look at the lowest input.
  always_comb begin
    expected = 1'b0;
    case (gate_q)
      3'd0:    expected = ~stim[0];
      3'd1:    expected = &stim;
      3'd2:    expected = |stim;
      3'd3:    expected = ~&stim;
      3'd4:    expected = ~|stim;
      3'd5:    expected = ^stim;
      3'd6:    expected = ~^stim;
      default: expected = stim[0];
    endcase
  end

  assign mismatch = (dut_y != expected);
  assign last_vec = &stim;
  assign busy     = (state == ST_SETTLE) || (state == ST_CHECK);
  assign done     = (state == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      wait_cnt  <= 4'd0;
      gate_q    <= 3'd0;
      stim      <= '0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      err_valid <= 1'b0;
      err_vec   <= '0;
    end else begin
      err_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            gate_q   <= gate_sel;
            stim     <= '0;
            pass_cnt <= '0;
            fail_cnt <= '0;
            wait_cnt <= 4'(SETTLE);
            state    <= ST_SETTLE;
          end
        end
        // The wait counter spans exactly SETTLE cycles, leaving the CHECK cycle to sample dut_y.
        ST_SETTLE: begin
          if (wait_cnt <= 4'd1) begin
            wait_cnt <= 4'd0;
            state    <= ST_CHECK;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_CHECK: begin
          if (mismatch) begin
            fail_cnt  <= fail_cnt + CNT_W'(1);
            err_valid <= 1'b1;
            err_vec   <= stim;
          end else begin
            pass_cnt  <= pass_cnt + CNT_W'(1);
          end
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
          if (last_vec || mismatch) begin
`else
          if (last_vec) begin
`endif
            state <= ST_DONE;
          end else begin
            stim     <= stim + N_IN'(1);
            wait_cnt <= 4'(SETTLE);
            state    <= ST_SETTLE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
